// File: rtl/cfs_apb_master.sv
// APB3 initiator: turns a valid/ready command stream into single APB transfers,
// one outstanding at a time, with a bounded wait-state timeout and one response per command.
module cfs_apb_master #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);

    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next, cnt_inc;
    logic [ADDR_WIDTH-1:0]   paddr_reg, paddr_next;
    logic                    pwrite_reg, pwrite_next;
    logic [DATA_WIDTH-1:0]   pwdata_reg, pwdata_next;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic                    rsp_err_reg, rsp_err_next;
    logic                    rsp_timeout_reg, rsp_timeout_next;
    logic                    cmd_ready_reg, cmd_ready_next;
    logic                    busy_reg, busy_next;
    logic                    psel_reg, psel_next;
    logic                    penable_reg, penable_next;
    logic                    rsp_valid_reg, rsp_valid_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            paddr_reg       <= '0;
            pwrite_reg      <= 1'b0;
            pwdata_reg      <= '0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            cmd_ready_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            paddr_reg       <= paddr_next;
            pwrite_reg      <= pwrite_next;
            pwdata_reg      <= pwdata_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
            cmd_ready_reg   <= cmd_ready_next;
            busy_reg        <= busy_next;
            psel_reg        <= psel_next;
            penable_reg     <= penable_next;
            rsp_valid_reg   <= rsp_valid_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        paddr_next       = paddr_reg;
        pwrite_next      = pwrite_reg;
        pwdata_next      = pwdata_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_err_next     = rsp_err_reg;
        rsp_timeout_next = rsp_timeout_reg;
        // Saturating increment: a long stall must never wrap back below the limit.
        cnt_inc          = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

        case (state_reg)
            ST_IDLE: begin
                // cmd_ready_reg gates acceptance so the first edge after reset cannot take a command.
                if (cmd_valid && cmd_ready_reg) begin
                    paddr_next  = cmd_addr;
                    pwrite_next = cmd_write;
                    pwdata_next = cmd_write ? cmd_wdata : '0;
                    cnt_next    = '0;
                    state_next  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    rsp_err_next     = pslverr;
                    rsp_rdata_next   = (!pwrite_reg && !pslverr) ? prdata : '0;
                    rsp_timeout_next = 1'b0;
                    state_next       = ST_RESP;
                end else begin
                    cnt_next = cnt_inc;
                    if ((TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIMIT)) begin
                        rsp_err_next     = 1'b1;
                        rsp_timeout_next = 1'b1;
                        rsp_rdata_next   = '0;
                        state_next       = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Status and APB strobes are decoded from the next state so every output is a flop.
        cmd_ready_next = (state_next == ST_IDLE);
        busy_next      = (state_next != ST_IDLE);
        psel_next      = (state_next == ST_SETUP) || (state_next == ST_ACCESS);
        penable_next   = (state_next == ST_ACCESS);
        rsp_valid_next = (state_next == ST_RESP);
    end

    assign cmd_ready   = cmd_ready_reg;
    assign busy        = busy_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign paddr       = paddr_reg;
    assign pwrite      = pwrite_reg;
    assign psel        = psel_reg;
    assign penable     = penable_reg;
    assign pwdata      = pwdata_reg;

endmodule

// File: doc/cfs_apb_master.md
# cfs_apb_master

APB initiator that converts a simple valid/ready command stream into single APB3 read/write transfers and returns one response per command. It drives the APB slave port of `cfs_aligner` (register block `cfs_regs`). It replaces the bench-only APB driver wherever a firmware-side or sequencer-side register master is needed. One transfer is outstanding at a time; slave wait states are bounded by a programmable timeout.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: width of `cmd_addr` and `paddr`.
- `DATA_WIDTH`, default 32: width of the write data, read data and APB data buses.
- `TIMEOUT_CYCLES`, default 255: maximum number of ACCESS cycles with `pready`=0 before the transfer is aborted. A value of 0 disables the timeout.

Ports:
- `clk` in 1: the single clock. All logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the block accepts a command. Asserted only in IDLE.
- `cmd_write` in 1: 1 selects a write, 0 selects a read.
- `cmd_addr` in ADDR_WIDTH: transfer address.
- `cmd_wdata` in DATA_WIDTH: write data. Ignored for reads.
- `rsp_valid` out 1: a response is available.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_rdata` out DATA_WIDTH: read data. It is 0 for writes and for errored transfers.
- `rsp_err` out 1: the slave returned `pslverr`, or the transfer timed out.
- `rsp_timeout` out 1: the transfer was aborted by the timeout.
- `busy` out 1: the state is not IDLE.
- `paddr` out ADDR_WIDTH: APB address.
- `pwrite` out 1: APB write strobe.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwdata` out DATA_WIDTH: APB write data.
- `pready` in 1: APB slave ready.
- `prdata` in DATA_WIDTH: APB read data.
- `pslverr` in 1: APB slave error.

## Operation
- Reset values: all outputs are 0, the state is IDLE, the timeout counter is 0. `cmd_ready` becomes 1 on the first clock edge after `reset` is released.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid` && `cmd_ready`, latch `cmd_addr`, `cmd_write` and `cmd_wdata` into `paddr`, `pwrite` and `pwdata`.
  - For reads, `pwdata` is forced to 0.
  - Next state is SETUP.
- SETUP: `psel`=1, `penable`=0. Next state is unconditionally ACCESS.
- ACCESS:
  - `psel`=1, `penable`=1.
  - `paddr`, `pwrite` and `pwdata` are stable from SETUP through the end of ACCESS.
  - If `pready`=1: capture `pslverr` into `rsp_err`. Capture `prdata` into `rsp_rdata` only if the transfer is a read and `pslverr`=0; otherwise `rsp_rdata` is 0. Set `rsp_timeout`=0. Next state is RESP.
  - If `pready`=0: increment the timeout counter. When the counter reaches `TIMEOUT_CYCLES` (and `TIMEOUT_CYCLES` is not 0), abort with `rsp_err`=1, `rsp_timeout`=1 and `rsp_rdata`=0. Next state is RESP.
- RESP:
  - `psel`=0, `penable`=0, `rsp_valid`=1.
  - Response fields are held stable until `rsp_valid` && `rsp_ready`.
  - On the handshake, the next state is IDLE and the timeout counter clears.
  - `paddr`, `pwrite` and `pwdata` keep their last values; they are not cleared.
- Timeout counter:
  - Width is `$clog2(TIMEOUT_CYCLES+1)`, with a minimum of 1 bit.
  - It saturates; it never wraps.
  - It clears on entry to SETUP.
- Commands are never buffered. `cmd_valid` is ignored outside IDLE, and commands presented outside IDLE are not lost because `cmd_ready`=0.
- `pslverr` and `prdata` are sampled only in ACCESS with `pready`=1. Values at any other time are ignored.
- Reset mid-transfer (any state): outputs go to their reset values asynchronously. The pending transfer is dropped and no response is produced.
- Registered-only outputs: no combinational path from any input to any output.

## Timing
- Command accepted at edge T:
  - SETUP (`psel`=1, `penable`=0) during cycle T+1.
  - ACCESS during cycle T+2.
  - With `pready`=1 in that cycle, `rsp_valid`=1 from cycle T+3.
- Each slave wait state adds one cycle to the response latency.
- With `rsp_ready` tied high, `cmd_ready` returns to 1 at T+4. Maximum throughput is one transfer every 4 cycles.
- Timeout:
  - ACCESS lasts at most `TIMEOUT_CYCLES` cycles with `pready`=0.
  - `psel` drops on the cycle after the last of them.
  - `rsp_valid` asserts in that same cycle.
- Back-pressure: `rsp_ready`=0 holds RESP indefinitely. `psel` stays 0 throughout.

## Test plan
- Write, zero wait states: write 0x0000_0000 to address 0x0000 with `pready`=1 -> `psel` high for exactly 2 cycles with `penable` high in the 2nd; `rsp_valid` at T+3 with `rsp_err`=0 and `rsp_rdata`=0.
- Read, 3 wait states: read address 0x000C with `pready` low for 3 ACCESS cycles, then high with `prdata`=0x0000_0102 -> `rsp_rdata`=0x0000_0102, `rsp_err`=0; `paddr` stable at 0x000C for all 5 APB cycles.
- Slave error: write address 0x00F4 with `pready`=1 and `pslverr`=1 -> `rsp_err`=1, `rsp_timeout`=0. Read returning `pslverr`=1 and `prdata`=0xDEAD_BEEF -> `rsp_rdata`=0.
- Timeout: `TIMEOUT_CYCLES`=4 and `pready` held 0 -> after 4 ACCESS cycles `psel`/`penable` fall; `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0. A late `pready`=1 is ignored.
- Back-pressure and back-to-back:
  - Hold `rsp_ready`=0 for 10 cycles with `cmd_valid` high -> `cmd_ready`=0 and the response is stable throughout.
  - Then hold `rsp_ready` high for 4 commands -> 4 responses in order, one every 4 cycles.
- Reset mid-ACCESS: assert `reset` while `penable`=1 -> all outputs are 0 immediately. No `rsp_valid` appears after release, and `cmd_ready`=1 one edge after release.
